// File: rtl/word_serializer_param.sv
// Buffers WORD_W-bit words in a small FIFO and streams them out as WORD_W/LANE_W lanes.
// Optional macro IDLE_COM_EN: Data_out carries IDLE_SYM instead of zero whenever valid_out is low.
module word_serializer_param #(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned LANE_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic [7:0]  IDLE_SYM   = 8'hBC
) (
    input  logic                        clk_4f,
    input  logic                        reset,
    input  logic                        valid_in,
    input  logic [WORD_W-1:0]           Data_in,
    output logic                        ready_in,
    output logic                        valid_out,
    output logic [LANE_W-1:0]           Data_out,
    output logic                        sop_out,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned N    = WORD_W / LANE_W;
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);
    localparam logic [CntW-1:0] Depth   = CntW'(FIFO_DEPTH);
`ifdef IDLE_COM_EN
    localparam logic [LANE_W-1:0] IdleLane = LANE_W'(IDLE_SYM);
`else
    localparam logic [LANE_W-1:0] IdleLane = '0;
`endif

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic [IdxW-1:0]   lane_q, lane_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [LANE_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              sop_q, sop_d;
    logic              ovf_q;
    logic              full, empty, wr_en, load;
    logic [WORD_W-1:0] head;

    // The shift register always holds the not-yet-emitted lanes at its leading end.
    function automatic logic [LANE_W-1:0] first_lane(input logic [WORD_W-1:0] w);
        if (MSB_FIRST) return w[WORD_W-1 -: LANE_W];
        else           return w[LANE_W-1:0];
    endfunction

    function automatic logic [WORD_W-1:0] drop_lane(input logic [WORD_W-1:0] w);
        if (MSB_FIRST) return w << LANE_W;
        else           return w >> LANE_W;
    endfunction

    assign full  = (count_q == Depth);
    assign empty = (count_q == '0);
    assign wr_en = valid_in && !full;
    assign head  = mem[rd_ptr_q];
    assign load  = ((state_q == StIdle) || (lane_q == LastIdx)) && !empty;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        sreg_d  = sreg_q;
        dout_d  = IdleLane;
        valid_d = 1'b0;
        sop_d   = 1'b0;
        if (load) begin
            state_d = StShift;
            lane_d  = '0;
            sreg_d  = drop_lane(head);
            dout_d  = first_lane(head);
            valid_d = 1'b1;
            sop_d   = 1'b1;
        end else if ((state_q == StShift) && (lane_q != LastIdx)) begin
            lane_d  = lane_q + IdxW'(1);
            sreg_d  = drop_lane(sreg_q);
            dout_d  = first_lane(sreg_q);
            valid_d = 1'b1;
        end else begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            lane_q   <= '0;
            sreg_q   <= '0;
            dout_q   <= IdleLane;
            valid_q  <= 1'b0;
            sop_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            sreg_q  <= sreg_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (load)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({wr_en, load})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
            if (valid_in && full) ovf_q <= 1'b1;
        end
    end

    // Storage is not reset; pointers and count alone define validity.
    always_ff @(posedge clk_4f) begin
        if (wr_en) mem[wr_ptr_q] <= Data_in;
    end

    assign ready_in   = !full;
    assign valid_out  = valid_q;
    assign Data_out   = dout_q;
    assign sop_out    = sop_q;
    assign overflow   = ovf_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_word_serializer_param.sv
// Bench for word_serializer_param: MSB-first and LSB-first instances share stimulus and
// are checked against a queue-based word/lane model; honours IDLE_COM_EN for the idle symbol.
module tb_word_serializer_param;

    localparam int DEPTH = 4;
    localparam int N     = 4;
`ifdef IDLE_COM_EN
    localparam logic [7:0] IDLE_EXP = 8'hBC;
`else
    localparam logic [7:0] IDLE_EXP = 8'h00;
`endif

    logic        clk_4f = 1'b0;
    logic        reset = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] Data_in = '0;
    logic        ready_m, valid_m, sop_m, ovf_m;
    logic [7:0]  dout_m;
    logic [2:0]  cnt_m;
    logic        ready_l, valid_l, sop_l, ovf_l;
    logic [7:0]  dout_l;
    logic [2:0]  cnt_l;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: pending words, the word being emitted and which lane of it is on the output.
    logic [31:0] mq[$];
    logic [31:0] cur = '0;
    bit          busy = 1'b0;
    int          idx = 0;
    bit          ovf = 1'b0;

    word_serializer_param dut_m (
        .clk_4f(clk_4f), .reset(reset), .valid_in(valid_in), .Data_in(Data_in),
        .ready_in(ready_m), .valid_out(valid_m), .Data_out(dout_m), .sop_out(sop_m),
        .overflow(ovf_m), .fifo_count(cnt_m)
    );

    word_serializer_param #(.MSB_FIRST(1'b0)) dut_l (
        .clk_4f(clk_4f), .reset(reset), .valid_in(valid_in), .Data_in(Data_in),
        .ready_in(ready_l), .valid_out(valid_l), .Data_out(dout_l), .sop_out(sop_l),
        .overflow(ovf_l), .fifo_count(cnt_l)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] lane_of(input logic [31:0] w, input int j, input bit msb);
        int sh;
        sh = msb ? 8 * (N - 1 - j) : 8 * j;
        return 8'((w >> sh) & 32'hFF);
    endfunction

    task automatic model_edge(input bit rst_n, input bit v, input logic [31:0] d);
        bit can_wr;
        if (!rst_n) begin
            mq.delete();
            busy = 1'b0;
            idx  = 0;
            ovf  = 1'b0;
        end else begin
            can_wr = (mq.size() < DEPTH);
            if (busy && idx < N - 1) begin
                idx++;
            end else if (mq.size() > 0) begin
                cur  = mq.pop_front();
                idx  = 0;
                busy = 1'b1;
            end else begin
                busy = 1'b0;
            end
            if (v && can_wr) mq.push_back(d);
            else if (v) ovf = 1'b1;
        end
    endtask

    task automatic check_outputs();
        check_eq("valid_m", valid_m, busy);
        check_eq("valid_l", valid_l, busy);
        check_eq("sop_m", sop_m, busy && idx == 0);
        check_eq("sop_l", sop_l, busy && idx == 0);
        check_eq("data_m", dout_m, busy ? lane_of(cur, idx, 1'b1) : IDLE_EXP);
        check_eq("data_l", dout_l, busy ? lane_of(cur, idx, 1'b0) : IDLE_EXP);
        check_eq("count_m", cnt_m, mq.size());
        check_eq("count_l", cnt_l, mq.size());
        check_eq("ready_m", ready_m, mq.size() < DEPTH);
        check_eq("ready_l", ready_l, mq.size() < DEPTH);
        check_eq("ovf_m", ovf_m, ovf);
        check_eq("ovf_l", ovf_l, ovf);
    endtask

    // Called at a falling edge: drive, let one rising edge pass, check at the next falling edge.
    task automatic cycle(input bit rst_n, input bit v, input logic [31:0] d);
        reset    = rst_n;
        valid_in = v;
        Data_in  = d;
        @(posedge clk_4f);
        model_edge(rst_n, v, d);
        @(negedge clk_4f);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        logic [7:0] t1 [4];
        logic [7:0] t4 [4];
        int p;
        t1 = '{8'hFF, 8'hAA, 8'hFF, 8'hBB};
        t4 = '{8'h03, 8'h0A, 8'h0F, 8'h01};
        @(negedge clk_4f);

        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        check_eq("rst_data", dout_m, IDLE_EXP);

        // Single word, lanes start one edge after accept.
        cycle(1'b1, 1'b1, 32'hFFAAFFBB);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 32'h0);
            check_eq("t1_lane", dout_m, t1[i]);
        end
        idle(3);
        check_eq("t1_idle", dout_m, IDLE_EXP);

        // Back-to-back words.
        cycle(1'b1, 1'b1, 32'hFFAAFFBB);
        cycle(1'b1, 1'b1, 32'hDDCCDDEE);
        idle(10);

        // Sustained valid_in fills the FIFO and drops words.
        for (int i = 1; i <= 10; i++) cycle(1'b1, 1'b1, 32'(i));
        check_eq("t3_ovf", ovf_m, 1'b1);
        idle(30);

        // Lane order on the LSB-first instance.
        cycle(1'b1, 1'b1, 32'h010F0A03);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 32'h0);
            check_eq("t4_lane", dout_l, t4[i]);
        end
        idle(2);

        // Reset after lane 1 of the first word with two words still queued.
        cycle(1'b1, 1'b1, 32'h11111111);
        cycle(1'b1, 1'b1, 32'h22222222);
        cycle(1'b1, 1'b1, 32'h33333333);
        cycle(1'b0, 1'b0, 32'h0);
        check_eq("t5_count", cnt_m, 3'd0);
        check_eq("t5_valid", valid_m, 1'b0);
        idle(8);

        // Word after idle gaps, then idle symbol resumes.
        cycle(1'b1, 1'b1, 32'h11223344);
        idle(6);
        check_eq("t6_idle", dout_m, IDLE_EXP);

        // Random traffic with varying load and occasional resets.
        for (int blk = 0; blk < 30; blk++) begin
            p = int'($urandom_range(0, 100));
            for (int i = 0; i < 100; i++) begin
                cycle($urandom_range(0, 299) != 0, int'($urandom_range(0, 99)) < p, $urandom);
            end
        end
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/word_serializer_param.md
Name: word_serializer_param

Overview:
- Parametrised successor to the fixed 32-to-8 word serializer in the lane datapath.
- Accepts WORD_W-bit words through a valid/ready handshake into a small FIFO, then emits them as N = WORD_W/LANE_W consecutive LANE_W-bit lanes on clk_4f.
- Adds buffering, back-to-back words with no gap, selectable lane order, start-of-word marking and drop detection.

Parameters:
- WORD_W, 32, input word width; must be an integer multiple of LANE_W.
- LANE_W, 8, output lane width.
- FIFO_DEPTH, 4, input FIFO entries; power of 2, minimum 2.
- MSB_FIRST, 1, 1 = most significant lane first; 0 = least significant lane first.
- IDLE_SYM, 8'hBC, idle symbol; used only with IDLE_COM_EN, zero-extended or truncated to LANE_W.

Ports:
- clk_4f  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- valid_in  in  1  Data_in valid.
- Data_in  in  WORD_W  input word.
- ready_in  out  1  FIFO can accept; combinational, equals !full.
- valid_out  out  1  Data_out carries a lane.
- Data_out  out  LANE_W  output lane, registered.
- sop_out  out  1  high with the first lane of each word.
- overflow  out  1  sticky flag: a word was dropped.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: sampled at a clk_4f edge while reset=0. It clears the FIFO pointers, fifo_count, FSM (to IDLE), lane index, valid_out, sop_out, overflow and Data_out (0, or IDLE_SYM with IDLE_COM_EN). ready_in reads 1 after reset.
- Reset mid-word: the partial word and all FIFO contents are discarded with no further lanes. The first non-reset edge behaves as from power-up.
- Write: occurs on an edge where valid_in && ready_in. Writes go to the tail.
- Full FIFO: no write occurs, even if a read happens on the same edge.
- Overflow: valid_in && !ready_in drops the word and sets overflow. overflow stays set until reset.
- Read/load:
  - A load occurs on an edge where (state==IDLE or lane_idx==N-1) and the FIFO is non-empty.
  - The head word is popped into the shift register.
  - On the same edge: Data_out <= first lane, valid_out <= 1, sop_out <= 1, lane_idx <= 0.
- FSM states: IDLE and SHIFT.
  - IDLE -> SHIFT on a load.
  - In SHIFT with lane_idx<N-1: each edge advances lane_idx, outputs the next lane, sop_out=0.
  - At lane_idx==N-1: a load (FIFO non-empty) keeps SHIFT. Otherwise go to IDLE with valid_out<=0 and Data_out<=0 (or IDLE_SYM).
- Latency: a word written at edge k into an empty FIFO with IDLE state shows lane 0 after edge k+1. Lanes follow on edges k+1 .. k+N.
- Throughput: back-to-back buffered words stream with zero idle cycles, i.e. one word per N cycles.
- Lane order:
  - MSB_FIRST=1: lane j = Data_in[WORD_W-1-j*LANE_W -: LANE_W].
  - MSB_FIRST=0: lane j = Data_in[j*LANE_W +: LANE_W].
- fifo_count: +1 on a write, -1 on a read, unchanged on a simultaneous write and read. Pointers wrap modulo FIFO_DEPTH.
- Degenerate case N=1: every edge with a non-empty FIFO loads. sop_out equals valid_out.

Optional Feature:
- Macro: IDLE_COM_EN.
- Defined: whenever valid_out=0 (including reset), Data_out drives IDLE_SYM for link comma alignment. valid_out and sop_out behave unchanged.
- Not defined: Data_out = 0 whenever valid_out=0.

Test Plan:
1. Defaults. reset=0 for 2 edges, then a single cycle valid_in=1 with Data_in=FFAAFFBB. -> Data_out FF,AA,FF,BB on 4 consecutive edges starting 1 edge after accept. sop_out only with FF. Then valid_out=0 and Data_out=00.
2. FFAAFFBB then DDCCDDEE on consecutive cycles. -> 8 contiguous lanes FF,AA,FF,BB,DD,CC,DD,EE. valid_out never drops between words. sop_out on FF and DD.
3. valid_in held 10 cycles with Data_in=00000001..0000000A. -> ready_in falls after fifo_count reaches 4. Non-accepted words are dropped and overflow=1. Output lanes are exactly the accepted words, in order.
4. MSB_FIRST=0 instance, Data_in=010F0A03. -> Data_out 03,0A,0F,01.
5. FIFO holding 2 words; reset=0 for 1 edge after lane 1 of the first word. -> next edge: valid_out=0, Data_out=00, fifo_count=0, overflow=0, ready_in=1. No stale lanes afterwards.
6. Compiled with IDLE_COM_EN. -> Data_out=BC during reset and idle gaps. A word 11223344 produces 11,22,33,44, then BC resumes with valid_out=0.
